// File: rtl/tc_conflict_monitor.sv
// Traffic-light conflict monitor: decodes highway/farm codes to lamps, checks for conflicts, illegal codes/sequences and dwell times, and latches a fault.
// Optional fault flashing is enabled with `define TC_MON_FLASH_EN.
module tc_conflict_monitor #(
  parameter int CNT_W      = 6,
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 3,
  parameter int MIN_ALLRED = 1,
  parameter int FLASH_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hy,
  input  logic [1:0] fr,
  input  logic       clr_fault,
  output logic [2:0] lamp_hy,
  output logic [2:0] lamp_fr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam logic [1:0] C_ILL    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_A_C   = CNT_W'(MIN_ALLRED);

  typedef enum logic {TRACK = 1'b0, FAULT = 1'b1} state_t;

  state_t           state;
  logic [1:0]       h_q, f_q;
  logic [CNT_W-1:0] dwell_h, dwell_f, allred_cnt;
  logic [2:0]       h_chk, f_chk, viol_code;
  logic             both_red, flash_hold;

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      C_GREEN:  decode = 3'b001;
      C_YELLOW: decode = 3'b010;
      default:  decode = 3'b100;
    endcase
  endfunction

  // Per-road transition check; returns 0 or one of the sequence/dwell codes 3..6.
  function automatic logic [2:0] road_check(input logic [1:0] prev, input logic [1:0] cur,
                                            input logic [CNT_W-1:0] dwell,
                                            input logic [CNT_W-1:0] allred);
    logic legal;
    legal = (prev == C_RED    && cur == C_GREEN)  ||
            (prev == C_GREEN  && cur == C_YELLOW) ||
            (prev == C_YELLOW && cur == C_RED);
    if (prev == cur)                                road_check = 3'd0;
    else if (!legal)                                road_check = 3'd3;
    else if (prev == C_GREEN  && dwell  < MIN_G_C)  road_check = 3'd4;
    else if (prev == C_YELLOW && dwell  < MIN_Y_C)  road_check = 3'd5;
    else if (prev == C_RED    && allred < MIN_A_C)  road_check = 3'd6;
    else                                            road_check = 3'd0;
  endfunction

  always_comb begin
    both_red  = (hy == C_RED) && (fr == C_RED);
    h_chk     = road_check(h_q, hy, dwell_h, allred_cnt);
    f_chk     = road_check(f_q, fr, dwell_f, allred_cnt);
    viol_code = 3'd0;
    if (hy != C_RED && fr != C_RED)        viol_code = 3'd1;
    else if (hy == C_ILL || fr == C_ILL)   viol_code = 3'd2;
    else if (h_chk != 3'd0 && (f_chk == 3'd0 || h_chk <= f_chk)) viol_code = h_chk;
    else                                   viol_code = f_chk;
  end

`ifdef TC_MON_FLASH_EN
  localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  logic [DIV_W-1:0] div_cnt;
  assign flash_hold = (div_cnt == DIV_W'(FLASH_DIV - 1)) ? ~flash : flash;
`else
  assign flash_hold = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= TRACK;
      h_q        <= C_RED;
      f_q        <= C_RED;
      dwell_h    <= CNT_MAX;
      dwell_f    <= CNT_MAX;
      allred_cnt <= MIN_A_C;
      lamp_hy    <= 3'b100;
      lamp_fr    <= 3'b100;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      flash      <= 1'b0;
`ifdef TC_MON_FLASH_EN
      div_cnt    <= '0;
`endif
    end else begin
      h_q <= hy;
      f_q <= fr;
      // Counters run in both states so a clear resumes with true dwell history.
      dwell_h    <= (hy != h_q) ? CNT_W'(1) : ((dwell_h == CNT_MAX) ? dwell_h : dwell_h + 1'b1);
      dwell_f    <= (fr != f_q) ? CNT_W'(1) : ((dwell_f == CNT_MAX) ? dwell_f : dwell_f + 1'b1);
      allred_cnt <= !both_red ? '0 : ((allred_cnt == CNT_MAX) ? allred_cnt : allred_cnt + 1'b1);
      case (state)
        TRACK: begin
          if (viol_code != 3'd0) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= viol_code;
            flash      <= 1'b1;
            lamp_hy    <= 3'b100;
            lamp_fr    <= 3'b100;
`ifdef TC_MON_FLASH_EN
            div_cnt    <= '0;
`endif
          end else begin
            lamp_hy <= decode(hy);
            lamp_fr <= decode(fr);
          end
        end
        FAULT: begin
          if (clr_fault && both_red) begin
            state      <= TRACK;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash      <= 1'b0;
            lamp_hy    <= decode(hy);
            lamp_fr    <= decode(fr);
          end else begin
            flash   <= flash_hold;
            lamp_hy <= {flash_hold, 2'b00};
            lamp_fr <= {flash_hold, 2'b00};
`ifdef TC_MON_FLASH_EN
            div_cnt <= (div_cnt == DIV_W'(FLASH_DIV - 1)) ? '0 : div_cnt + 1'b1;
`endif
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_conflict_monitor.sv
// Scoreboard bench for tc_conflict_monitor: directed light-code vectors with hand-written expected lamps/fault per cycle.
module tb_tc_conflict_monitor;

  localparam logic [1:0] R = 2'b10, G = 2'b00, Y = 2'b01, X = 2'b11;
  localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;
  localparam int W = 11;

  logic       clk;
  logic       rst_n;
  logic [1:0] hy, fr;
  logic       clr_fault;
  logic [2:0] lamp_hy, lamp_fr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           step_no = 0;

  tc_conflict_monitor dut (
    .clk       (clk),
    .rst       (rst_n),
    .hy        (hy),
    .fr        (fr),
    .clr_fault (clr_fault),
    .lamp_hy   (lamp_hy),
    .lamp_fr   (lamp_fr),
    .fault     (fault),
    .fault_code(fault_code),
    .flash     (flash)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: apply inputs on negedge, expect the response after the next posedge
  task automatic step(input logic r, input logic [1:0] h, input logic [1:0] f, input logic c,
                      input logic [2:0] elh, input logic [2:0] elf, input logic ef,
                      input logic [2:0] ec);
    @(negedge clk);
    rst_n = r; hy = h; fr = f; clr_fault = c;
    step_no++;
    exp_q.push_back({elh, elf, ef, ec, ef});
    id_q.push_back(step_no);
  endtask

  task automatic hold(input int n, input logic [1:0] h, input logic [1:0] f,
                      input logic [2:0] elh, input logic [2:0] elf);
    for (int i = 0; i < n; i++) step(1'b1, h, f, 1'b0, elh, elf, 1'b0, 3'd0);
  endtask

  task automatic clear_ok;
    step(1'b1, R, R, 1'b1, LR, LR, 1'b0, 3'd0);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e, a, m;
    int id;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {lamp_hy, lamp_fr, fault, fault_code, flash};
      m  = '1;
`ifdef TC_MON_FLASH_EN
      if (e[4]) m = 11'b011_011_1_111_0;
`endif
      n_cmp++;
      if ((a & m) !== (e & m)) begin
        n_err++;
        $display("FAIL step%0d lamps/fault: got hy=%b fr=%b fault=%b code=%0d flash=%b, want hy=%b fr=%b fault=%b code=%0d flash=%b",
                 id, a[10:8], a[7:5], a[4], a[3:1], a[0], e[10:8], e[7:5], e[4], e[3:1], e[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; hy = R; fr = R; clr_fault = 1'b0;
    // reset state
    step(1'b0, R, R, 1'b0, LR, LR, 1'b0, 3'd0);
    step(1'b0, R, R, 1'b0, LR, LR, 1'b0, 3'd0);
    hold(1, R, R, LR, LR);

    // normal cycling, two full rounds
    for (int k = 0; k < 2; k++) begin
      hold(30, G, R, LG, LR);
      hold(3,  Y, R, LY, LR);
      hold(1,  R, R, LR, LR);
      hold(15, R, G, LR, LG);
      hold(3,  R, Y, LR, LY);
      hold(1,  R, R, LR, LR);
    end

    // conflict
    step(1'b1, G, G, 1'b0, LR, LR, 1'b1, 3'd1);
    clear_ok();

    // illegal code, later conflict keeps code 2
    hold(1, R, R, LR, LR);
    step(1'b1, X, R, 1'b0, LR, LR, 1'b1, 3'd2);
    step(1'b1, G, G, 1'b0, LR, LR, 1'b1, 3'd2);
    // clear refused while a road is non-red
    step(1'b1, Y, R, 1'b1, LR, LR, 1'b1, 3'd2);
    clear_ok();

    // green straight to red
    hold(10, G, R, LG, LR);
    step(1'b1, R, R, 1'b0, LR, LR, 1'b1, 3'd3);
    clear_ok();

    // short green
    hold(5, G, R, LG, LR);
    step(1'b1, Y, R, 1'b0, LR, LR, 1'b1, 3'd4);
    clear_ok();

    // short yellow (green exactly at minimum is legal)
    hold(8, G, R, LG, LR);
    hold(2, Y, R, LY, LR);
    step(1'b1, R, R, 1'b0, LR, LR, 1'b1, 3'd5);
    clear_ok();

    // short all-red
    hold(8, G, R, LG, LR);
    hold(3, Y, R, LY, LR);
    step(1'b1, R, G, 1'b0, LR, LR, 1'b1, 3'd6);
    clear_ok();

    // clr_fault in TRACK does nothing; lamps resume decode
    step(1'b1, R, R, 1'b1, LR, LR, 1'b0, 3'd0);
    hold(9, G, R, LG, LR);

    // reset in the middle of a fault
    step(1'b1, G, G, 1'b0, LR, LR, 1'b1, 3'd1);
    step(1'b1, G, G, 1'b0, LR, LR, 1'b1, 3'd1);
    step(1'b0, R, R, 1'b0, LR, LR, 1'b0, 3'd0);
    hold(1, R, R, LR, LR);
    hold(4, R, G, LR, LG);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
